// File: rtl/pu_riscv_ram_fifo.sv
// Circular-buffer fall-through FIFO with registered level and programmable almost flags.
// Define PU_RISCV_RAM_FIFO_ERR_EN to build the sticky overflow/underflow detectors.
module pu_riscv_ram_fifo #(
  parameter  int DEPTH = 8,
  parameter  int DBITS = 64,
  localparam int LBITS = $clog2(DEPTH+1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             ena_i,
  input  logic             we_i,
  input  logic [DBITS-1:0] d_i,
  input  logic             re_i,
  output logic [DBITS-1:0] q_o,
  input  logic [LBITS-1:0] ae_thr_i,
  input  logic [LBITS-1:0] af_thr_i,
  output logic [LBITS-1:0] level_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             almost_empty_o,
  output logic             almost_full_o,
  output logic             overflow_o,
  output logic             underflow_o
);

  localparam int PBITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DBITS-1:0] mem_q [DEPTH];
  logic [PBITS-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [LBITS-1:0] level_q, level_d;
  logic             empty_q, full_q, ae_q, af_q;
  logic             upd, pop_ok, push_ok;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PBITS-1:0] ptr_inc(input logic [PBITS-1:0] p);
    return (p == PBITS'(DEPTH-1)) ? '0 : p + PBITS'(1);
  endfunction

  always_comb begin
    upd      = ena_i & ~clr_i;
    pop_ok   = upd & re_i & ~empty_q;
    push_ok  = upd & we_i & (~full_q | pop_ok);
    rd_ptr_d = pop_ok  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push_ok ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    level_d  = level_q + LBITS'(push_ok) - LBITS'(pop_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
    end else if (clr_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ae_q     <= 1'b1;
      af_q     <= 1'b0;
    end else if (ena_i) begin
      // Flags track level_d every enabled cycle so threshold edits land without traffic.
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      level_q  <= level_d;
      empty_q  <= (level_d == '0);
      full_q   <= (level_d == LBITS'(DEPTH));
      ae_q     <= (level_d <= ae_thr_i);
      af_q     <= (level_d >= af_thr_i);
    end
  end

  // Storage is never cleared; stale entries are hidden by empty_q.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= d_i;
  end

  assign q_o            = empty_q ? '0 : mem_q[rd_ptr_q];
  assign level_o        = level_q;
  assign empty_o        = empty_q;
  assign full_o         = full_q;
  assign almost_empty_o = ae_q;
  assign almost_full_o  = af_q;

`ifdef PU_RISCV_RAM_FIFO_ERR_EN
  logic ovf_q, unf_q, ovf_set, unf_set;

  assign ovf_set = upd & we_i & ~push_ok;
  assign unf_set = upd & re_i & ~pop_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (clr_i) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      if (ovf_set) ovf_q <= 1'b1;
      if (unf_set) unf_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni && ovf_set) $display("pu_riscv_ram_fifo (%m): overflow @%0t", $time);
    if (rst_ni && unf_set) $display("pu_riscv_ram_fifo (%m): underflow @%0t", $time);
  end
`endif

  assign overflow_o  = ovf_q;
  assign underflow_o = unf_q;
`else
  assign overflow_o  = 1'b0;
  assign underflow_o = 1'b0;
`endif

endmodule

// File: doc/pu_riscv_ram_fifo.md
Name: pu_riscv_ram_fifo

Overview:
Second-generation fall-through queue for the RISC-V memory path. It is a circular-buffer FIFO rather than a shift register and supports any DEPTH of 2 or more, including non-power-of-two values. It adds a registered fill level, runtime-programmable almost-empty/almost-full thresholds, and optional sticky overflow/underflow detection. It sits between the AHB-Lite bus interface and the core load/store/fetch units, wherever a shift-based queue was used before.

Parameters:
- DEPTH, 8, number of entries; legal range is 2 or more; need not be a power of two.
- DBITS, 64, data width in bits.
- LBITS, derived localparam = $clog2(DEPTH+1); width of the level and threshold fields.

Ports:
- clk_i, input, 1, rising-edge clock.
- rst_ni, input, 1, reset; asynchronous, active low.
- clr_i, input, 1, synchronous clear; has priority over ena_i.
- ena_i, input, 1, clock enable; when 0, all state holds.
- we_i, input, 1, push request.
- d_i, input, DBITS, push data.
- re_i, input, 1, pop request.
- q_o, output, DBITS, head-of-queue data (fall-through).
- ae_thr_i, input, LBITS, almost-empty threshold.
- af_thr_i, input, LBITS, almost-full threshold.
- level_o, output, LBITS, number of stored entries.
- empty_o, output, 1, queue empty.
- full_o, output, 1, queue full.
- almost_empty_o, output, 1, level <= ae_thr_i.
- almost_full_o, output, 1, level >= af_thr_i.
- overflow_o, output, 1, sticky: a push was rejected.
- underflow_o, output, 1, sticky: a pop was rejected.

Behaviour:
- Storage: mem[DEPTH] of DBITS, plus rd_ptr, wr_ptr and a level counter.
- Pointer wrap: a pointer at DEPTH-1 wraps to 0. No power-of-two arithmetic is used.
- Accept rules, evaluated only when ena_i=1 and clr_i=0:
  - pop_ok = re_i & ~empty_o.
  - push_ok = we_i & (~full_o | pop_ok).
- On push_ok: mem[wr_ptr] <= d_i; wr_ptr advances.
- On pop_ok: rd_ptr advances.
- Level update: level_next = level + push_ok - pop_ok.
- Full with we_i=1 and re_i=1: both accepted; level stays at DEPTH; the new data lands in the freed slot.
- Empty with we_i=1 and re_i=1: the push is accepted and the pop is rejected. There is no same-cycle bypass. Level becomes 1, and q_o = d_i from the next cycle.
- q_o = mem[rd_ptr] (combinational from registered state) when ~empty_o; q_o = 0 when empty_o.
- Fall-through latency: one push cycle, after which the data appears on q_o and empty_o drops at the same edge.
- Flags are registered from level_next and are re-evaluated on every enabled cycle:
  - empty_o = (level_next == 0).
  - full_o = (level_next == DEPTH).
  - almost_empty_o = (level_next <= ae_thr_i).
  - almost_full_o = (level_next >= af_thr_i).
  - level_o = level_next.
- A threshold change is therefore reflected at the next enabled edge even when no push or pop occurs.
- Threshold values above DEPTH are legal; comparisons are plain unsigned.
- Reset (async) and clr_i (sync) both set:
  - rd_ptr = 0, wr_ptr = 0, level_o = 0.
  - empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = 0.
  - overflow_o = 0, underflow_o = 0, q_o = 0.
  - mem contents are not cleared; they are masked by empty_o.
- clr_i during an active push/pop: the clear wins, and that cycle's push and pop are discarded.
- ena_i=0: pointers, level, flags and mem all hold, and the request inputs are ignored.

Optional Feature:
- Macro: PU_RISCV_RAM_FIFO_ERR_EN.
- Defined:
  - overflow_o sets on an enabled cycle with we_i & ~push_ok.
  - underflow_o sets on an enabled cycle with re_i & ~pop_ok.
  - Both stay set until rst_ni or clr_i.
  - Simulation additionally prints "pu_riscv_ram_fifo (%m): overflow/underflow @<time>".
- Undefined: overflow_o and underflow_o are tied to 0 and no error logic is synthesised. Queue behaviour is otherwise identical.

Test Plan (DEPTH=5, DBITS=8, ae_thr_i=1, af_thr_i=4):
- Reset, then push 0x11 -> next cycle q_o=0x11, empty_o=0, level_o=1, almost_empty_o=1, almost_full_o=0.
- Push 0x11..0x55 on consecutive cycles -> full_o=1, level_o=5, almost_full_o=1. Then pop 5 times -> q_o sequence 0x11,0x22,0x33,0x44,0x55, then 0 with empty_o=1.
- Full queue, we_i=re_i=1 with d_i=0x66 -> level_o stays 5, q_o advances to 0x22. After four more pops, q_o=0x66. Repeat for 12 cycles to exercise rd_ptr/wr_ptr wrap past index 4.
- Empty queue, we_i=re_i=1 with d_i=0x77 -> level_o=1, q_o=0x77 next cycle. With ERR_EN, underflow_o=1 and stays 1 until clr_i.
- Full queue, we_i=1, re_i=0 -> data unchanged, level_o=5, overflow_o=1 with ERR_EN (0 without). Then assert clr_i together with we_i -> level_o=0, empty_o=1, overflow_o=0, q_o=0.
- level_o=3 with no traffic: change af_thr_i from 4 to 3 -> almost_full_o=1 at the next edge. Then set ena_i=0 and change af_thr_i to 5 -> almost_full_o holds at 1 until ena_i returns to 1.
